// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
package fetch_pkg;
  localparam int PC_W = 32;
  localparam logic [PC_W-1:0] NOP_INST = 32'h00000015;
  typedef enum logic [1:0] {RST, FETCH, HOLD} fetch_state_t;
endpackage

// File: rtl/fetch_hold_buf.sv
// fetch_hold_buf: parks a fetched instruction and its link addresses while decode stalls.
module fetch_hold_buf import fetch_pkg::*; (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [PC_W-1:0] d_inst,
  input  logic [PC_W-1:0] d_p4,
  input  logic [PC_W-1:0] d_p8,
  output logic [PC_W-1:0] q_inst,
  output logic [PC_W-1:0] q_p4,
  output logic [PC_W-1:0] q_p8
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      q_inst <= '0;
      q_p4   <= '0;
      q_p8   <= '0;
    end else if (load) begin
      q_inst <= d_inst;
      q_p4   <= d_p4;
      q_p8   <= d_p8;
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner and instruction-memory handshake feeding IF/ID, with delayed branches.
// Optional FETCH_PERF_EN adds saturating completion and wait-cycle counters.
module fetch_unit import fetch_pkg::*; #(
  parameter logic [PC_W-1:0] RESET_PC = 32'h00000000,
  parameter logic [PC_W-1:0] NOP_INST = fetch_pkg::NOP_INST
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            branch,
  input  logic [PC_W-1:0] branchtarget,
  input  logic            jump,
  input  logic [PC_W-1:0] jumptarget,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [PC_W-1:0] imem_rdata,
  output logic [PC_W-1:0] inst_out,
  output logic [PC_W-1:0] pc_plus4,
  output logic [PC_W-1:0] pc_plus8,
  output logic            bubble
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetches,
  output logic [31:0]     perf_wait_cycles
`endif
);
  fetch_state_t state;
  logic [PC_W-1:0] pc, pend_pc, tgt, next_pc, h_inst, h_p4, h_p8;
  logic pend_v, redir, done;
  assign redir = jump | branch;
  assign tgt = (jump ? jumptarget : branchtarget) & ~32'h3;
  assign done = state == FETCH && imem_ready;
  assign next_pc = redir ? tgt : pend_v ? pend_pc : pc + 32'd4;
  assign imem_req = state == FETCH;
  assign imem_addr = pc;
  assign inst_out = state == HOLD ? h_inst : done ? imem_rdata : NOP_INST;
  assign pc_plus4 = state == HOLD ? h_p4 : pc + 32'd4;
  assign pc_plus8 = state == HOLD ? h_p8 : pc + 32'd8;
  assign bubble = state == RST ? 1'b1 : state == FETCH ? !imem_ready && !stall : 1'b0;
  fetch_hold_buf u_hold (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (done && stall),
    .d_inst (imem_rdata),
    .d_p4   (pc + 32'd4),
    .d_p8   (pc + 32'd8),
    .q_inst (h_inst),
    .q_p4   (h_p4),
    .q_p8   (h_p8)
  );
  // Redirects that arrive without a completing access wait in pend_pc; the delay slot is never lost.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= RST;
      pc      <= RESET_PC;
      pend_pc <= '0;
      pend_v  <= 1'b0;
    end else begin
      case (state)
        FETCH:
          if (imem_ready) begin
            pc     <= next_pc;
            pend_v <= 1'b0;
            if (stall) state <= HOLD;
          end else if (redir) begin
            pend_pc <= tgt;
            pend_v  <= 1'b1;
          end
        HOLD:
          if (!stall) begin
            pc     <= redir ? tgt : pend_v ? pend_pc : pc;
            pend_v <= 1'b0;
            state  <= FETCH;
          end else if (redir) begin
            pend_pc <= tgt;
            pend_v  <= 1'b1;
          end
        default: begin
          state <= FETCH;
          if (redir) begin
            pend_pc <= tgt;
            pend_v  <= 1'b1;
          end
        end
      endcase
    end
`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      perf_fetches     <= '0;
      perf_wait_cycles <= '0;
    end else if (state == FETCH) begin
      if (imem_ready && perf_fetches != '1) perf_fetches <= perf_fetches + 32'd1;
      if (!imem_ready && perf_wait_cycles != '1) perf_wait_cycles <= perf_wait_cycles + 32'd1;
    end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit against a behavioural model.
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h00000015;
  logic clk = 1'b0;
  logic rst_n, stall, branch, jump, imem_ready, imem_req, bubble;
  logic [31:0] branchtarget, jumptarget, imem_rdata, imem_addr, inst_out, pc_plus4, pc_plus8;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetches, perf_wait_cycles;
  logic [31:0] m_pf, m_pw;
`endif
  int total = 0, bad = 0;
  int m_mode;
  bit m_pv;
  logic [31:0] m_pc, m_pend, m_hi, m_h4, m_h8;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch(branch), .branchtarget(branchtarget),
    .jump(jump), .jumptarget(jumptarget), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .inst_out(inst_out),
    .pc_plus4(pc_plus4), .pc_plus8(pc_plus8), .bubble(bubble)
`ifdef FETCH_PERF_EN
    , .perf_fetches(perf_fetches), .perf_wait_cycles(perf_wait_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset;
    m_mode = 0; m_pc = 32'h0; m_pv = 0;
    m_hi = 0; m_h4 = 0; m_h8 = 0;
`ifdef FETCH_PERF_EN
    m_pf = 0; m_pw = 0;
`endif
  endtask

  // Expected outputs for the current state (mode 0=RST, 1=FETCH, 2=HOLD) and current inputs.
  task automatic check;
    logic er, eb;
    logic [31:0] ei, e4, e8;
    er = m_mode == 1;
    ei = m_mode == 2 ? m_hi : (m_mode == 1 && imem_ready) ? imem_rdata : NOP;
    e4 = m_mode == 2 ? m_h4 : m_pc + 4;
    e8 = m_mode == 2 ? m_h8 : m_pc + 8;
    eb = m_mode == 0 ? 1'b1 : m_mode == 1 ? (!imem_ready && !stall) : 1'b0;
    chk("imem_req", {31'd0, imem_req}, {31'd0, er});
    if (er) chk("imem_addr", imem_addr, m_pc);
    chk("inst_out", inst_out, ei);
    chk("pc_plus4", pc_plus4, e4);
    chk("pc_plus8", pc_plus8, e8);
    chk("bubble", {31'd0, bubble}, {31'd0, eb});
`ifdef FETCH_PERF_EN
    chk("perf_fetches", perf_fetches, m_pf);
    chk("perf_wait", perf_wait_cycles, m_pw);
`endif
  endtask

  task automatic update;
    bit rd;
    logic [31:0] t;
    rd = jump || branch;
    t = (jump ? jumptarget : branchtarget) & 32'hFFFFFFFC;
    if (m_mode == 1 && imem_ready) begin
`ifdef FETCH_PERF_EN
      if (m_pf != 32'hFFFFFFFF) m_pf++;
`endif
      if (stall) begin m_hi = imem_rdata; m_h4 = m_pc + 4; m_h8 = m_pc + 8; end
      m_pc = rd ? t : m_pv ? m_pend : m_pc + 4;
      m_pv = 0;
      m_mode = stall ? 2 : 1;
    end else if (m_mode == 2 && !stall) begin
      m_pc = rd ? t : m_pv ? m_pend : m_pc;
      m_pv = 0;
      m_mode = 1;
    end else begin
`ifdef FETCH_PERF_EN
      if (m_mode == 1 && m_pw != 32'hFFFFFFFF) m_pw++;
`endif
      if (rd) begin m_pend = t; m_pv = 1; end
      if (m_mode == 0) m_mode = 1;
    end
  endtask

  task automatic apply(input bit rdy, input bit st, input bit br, input logic [31:0] bt,
                       input bit jp, input logic [31:0] jt, input logic [31:0] rd);
    imem_ready = rdy; stall = st; branch = br; branchtarget = bt;
    jump = jp; jumptarget = jt; imem_rdata = rd;
    #1;
    check();
    update();
  endtask

  task automatic cyc(input bit rdy, input bit st, input bit br, input logic [31:0] bt,
                     input bit jp, input logic [31:0] jt, input logic [31:0] rd);
    @(negedge clk);
    apply(rdy, st, br, bt, jp, jt, rd);
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_req_drop", {31'd0, imem_req}, 32'd0);
    check();
    @(negedge clk);
    rst_n = 1'b1;
    apply(0, 0, 0, 0, 0, 0, $urandom);
  endtask

  initial begin
    rst_n = 1'b0; stall = 0; branch = 0; jump = 0; imem_ready = 0;
    branchtarget = 0; jumptarget = 0; imem_rdata = 0;
    do_reset();
    chk("L_rst_inst", inst_out, NOP);
    chk("L_rst_p4", pc_plus4, 32'h4);
    chk("L_rst_p8", pc_plus8, 32'h8);
    chk("L_rst_bubble", {31'd0, bubble}, 32'd1);
    cyc(1, 0, 0, 0, 0, 0, $urandom);
    chk("L_addr0", imem_addr, 32'h0);
    chk("L_p4_0", pc_plus4, 32'h4);
    chk("L_bub0", {31'd0, bubble}, 32'd0);
    cyc(1, 1, 0, 0, 0, 0, 32'hAABBCCDD);
    chk("L_addr4", imem_addr, 32'h4);
    chk("L_stall_inst", inst_out, 32'hAABBCCDD);
    chk("L_stall_bub", {31'd0, bubble}, 32'd0);
    cyc(0, 1, 0, 0, 0, 0, $urandom);
    chk("L_hold_req", {31'd0, imem_req}, 32'd0);
    chk("L_hold_inst", inst_out, 32'hAABBCCDD);
    cyc(0, 0, 0, 0, 0, 0, $urandom);
    chk("L_hold_inst2", inst_out, 32'hAABBCCDD);
    repeat (3) begin
      cyc(0, 0, 0, 0, 0, 0, $urandom);
      chk("L_wait_addr8", imem_addr, 32'h8);
      chk("L_wait_nop", inst_out, NOP);
      chk("L_wait_bub", {31'd0, bubble}, 32'd1);
    end
    cyc(1, 0, 0, 0, 0, 0, 32'h12345678);
    chk("L_late_inst", inst_out, 32'h12345678);
    chk("L_late_p4", pc_plus4, 32'hC);
    repeat (2) begin
      cyc(0, 0, 1, 32'h100, 0, 0, $urandom);
      chk("L_br_wait_addr", imem_addr, 32'hC);
    end
    cyc(1, 0, 0, 0, 0, 0, 32'h0BADF00D);
    chk("L_slot_addr", imem_addr, 32'hC);
    chk("L_slot_inst", inst_out, 32'h0BADF00D);
    cyc(1, 0, 1, 32'h100, 1, 32'h200, $urandom);
    chk("L_br_addr", imem_addr, 32'h100);
    cyc(1, 0, 0, 0, 1, 32'hFFFFFFFF, $urandom);
    chk("L_jmp_addr", imem_addr, 32'h200);
    cyc(1, 0, 0, 0, 0, 0, $urandom);
    chk("L_top_addr", imem_addr, 32'hFFFFFFFC);
    chk("L_wrap_p4", pc_plus4, 32'h0);
    cyc(1, 0, 0, 0, 1, 32'h10, $urandom);
    chk("L_wrap_addr", imem_addr, 32'h0);
    cyc(0, 0, 0, 0, 0, 0, $urandom);
    chk("L_addr10", imem_addr, 32'h10);
    #2;
    do_reset();
    chk("L_rstcyc_req", {31'd0, imem_req}, 32'd0);
    repeat (3) begin
      cyc(0, 0, 0, 0, 0, 0, $urandom);
      chk("L_after_rst_addr", imem_addr, 32'h0);
    end
    repeat (5) cyc(1, 0, 0, 0, 0, 0, $urandom);
    cyc(0, 0, 0, 0, 0, 0, $urandom);
`ifdef FETCH_PERF_EN
    chk("L_perf_fetches", perf_fetches, 32'd5);
    chk("L_perf_wait", perf_wait_cycles, 32'd3);
`endif
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        @(negedge clk);
        #($urandom_range(1, 3));
        do_reset();
      end else begin
        cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
            $urandom, $urandom_range(0, 19) == 0, $urandom, $urandom);
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage. Owns the PC and the instruction-memory handshake.
- Drives the IF/ID inputs of the decode stage: instruction, PC+4 (delay-slot address, the base for the branch target), PC+8 (link value) and a bubble/squash request.
- Consumes the stall, branch and jump redirects coming back from decode.
- Branches and jumps are delayed: the instruction being fetched when a redirect arrives is the delay slot. It is always delivered; only the following PC changes.

Parameters:
- RESET_PC, 32'h00000000, PC loaded on reset.
- NOP_INST, 32'h00000015, instruction driven whenever no valid fetch is presented.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  decode stage holding; fetch must not advance.
- branch  in  1  taken-branch redirect from decode.
- branchtarget  in  32  branch target.
- jump  in  1  jump redirect from decode.
- jumptarget  in  32  jump/jar target.
- imem_req  out  1  instruction-memory request.
- imem_addr  out  32  word address (current PC, bits[1:0]=00).
- imem_ready  in  1  access completes this cycle.
- imem_rdata  in  32  instruction, valid when imem_req&&imem_ready.
- inst_out  out  32  to decode dinst.
- pc_plus4  out  32  to decode ddelay.
- pc_plus8  out  32  to decode ddelay2.
- bubble  out  1  to decode squash; inserts NOP into IF/ID.

Behaviour:
- States: RST, FETCH, HOLD.
  - RST is entered on reset and lasts exactly one cycle after rst_n deasserts, with imem_req=0. It then goes to FETCH.
- Reset (async, any time, including mid-access):
  - pc=RESET_PC, state=RST, redirect_pending=0, hold buffer cleared.
  - Outputs: imem_req=0, inst_out=NOP_INST, pc_plus4=RESET_PC+4, pc_plus8=RESET_PC+8, bubble=1.
  - An outstanding memory access is abandoned.
- Handshake:
  - In FETCH, imem_req=1 and imem_addr=pc.
  - Address is held stable until imem_req&&imem_ready.
  - The transfer completes in that cycle. Memory latency is unbounded.
- FETCH, completion, stall=0:
  - inst_out=imem_rdata (combinational), pc_plus4=pc+4, pc_plus8=pc+8, bubble=0.
  - Next edge: pc<=next_pc.
- FETCH, completion, stall=1:
  - Capture imem_rdata, pc+4 and pc+8 into the hold buffer; go to HOLD.
  - pc<=next_pc. bubble=0. Decode ignores the offered data because it is stalled.
- FETCH, no completion:
  - inst_out=NOP_INST, bubble=1 when stall=0. With stall=1, bubble=0 so the stall is not overridden.
  - pc is unchanged.
- HOLD:
  - imem_req=0; outputs driven from the hold buffer; bubble=0.
  - Stays in HOLD while stall=1; goes to FETCH on the first edge with stall=0.
- next_pc priority: jump → jumptarget; else branch → branchtarget; else redirect_pending → pending target; else pc+4. Arithmetic is modulo 2^32; PC wraps from FFFFFFFC to 00000000.
- Redirect while no completion (FETCH without ready, or HOLD):
  - Latch the target into a pending register with the same jump>branch priority.
  - A later redirect overwrites an earlier one.
  - The pending target is consumed when the next access completes, or at the first fetch after HOLD.
  - The pending register is cleared when consumed.
- A redirect and a completion in the same cycle apply directly, with no pending entry.
- Redirects held high across stall cycles are idempotent.
- Target bits[1:0] are forced to 00.

Optional Feature:
- FETCH_PERF_EN.
- Defined:
  - Adds out ports perf_fetches[31:0] (completed accesses) and perf_wait_cycles[31:0] (FETCH cycles with imem_req&&!imem_ready).
  - Both reset to 0 and saturate at FFFFFFFF.
- Undefined: these ports and counters are absent; the rest of the behaviour is identical.

Decomposition:
- Package fetch_pkg:
  - NOP_INST constant.
  - fetch_state_t enum {RST, FETCH, HOLD}.
  - PC_W=32.
- One sub-module, fetch_hold_buf: three 32-bit registers with load enable and async clear, used for HOLD.

Test Plan:
- imem_ready tied 1, no stall/redirect → imem_addr 0,4,8,C on consecutive cycles; pc_plus4=4,8,C,10; bubble=0 from the 2nd cycle after reset.
- imem_ready low 3 cycles at addr 8 → addr held at 8; inst_out=00000015 and bubble=1 for 3 cycles; then rdata delivered with pc_plus4=C.
- stall=1 in the cycle addr 4 completes with rdata=AABBCCDD, held 2 cycles → HOLD, imem_req=0, inst_out stays AABBCCDD; after release the next addr is 8.
- branch=1, branchtarget=100 while addr C is waiting 2 cycles → instruction at C still delivered (delay slot); next addr=100.
- jump (target 200) and branch (target 100) in the same cycle → next addr 200.
- rst_n low mid-wait at addr 10 → imem_req drops immediately; after release one RST cycle, then addr=RESET_PC.
- FETCH_PERF_EN: 5 completions and 3 wait cycles → perf_fetches=5, perf_wait_cycles=3.
